// File: rtl/alu_op_issue_if.sv
// Bundle of the request and issue handshake signals of the ALU operation issue stage.
// master drives requests and consumes ops; slave is the issue stage itself.
interface alu_op_issue_if #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5,
    parameter int CNT_WIDTH     = 16
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               ALUOp;
    logic                     Jump;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic [TAG_WIDTH-1:0]     TagIn;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [TAG_WIDTH-1:0]     TagOut;
    logic                     Illegal;
    logic [CNT_WIDTH-1:0]     IllegalCnt;

    modport master (
        output flush, in_valid, ALUOp, Jump, Funct3, Funct7, TagIn, out_ready,
        input  in_ready, out_valid, Operation, TagOut, Illegal, IllegalCnt
    );

    modport slave (
        input  flush, in_valid, ALUOp, Jump, Funct3, Funct7, TagIn, out_ready,
        output in_ready, out_valid, Operation, TagOut, Illegal, IllegalCnt
    );
endinterface

// File: rtl/alu_op_issue.sv
// ALU operation decoder feeding an elastic ID/EX issue stage (output register + skid entry).
// Optional macro ALU_OP_ILLEGAL_CNT_EN builds a saturating counter of accepted illegal ops.
module alu_op_issue #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_op_issue_if.slave      bus
);

    // Returns {illegal, operation}; an illegal encoding yields operation 0000.
    function automatic logic [4:0] decode_op(
        input logic [1:0] aluop,
        input logic       jump,
        input logic [2:0] f3,
        input logic [6:0] f7
    );
        logic       f7_zero;
        logic       f7_alt;
        logic [4:0] res;
        f7_zero = (f7 == 7'b0000000);
        f7_alt  = (f7 == 7'b0100000);
        res     = 5'b1_0000;
        if (jump) begin
            res = 5'b0_1101;
        end else begin
            case (aluop)
                2'b00: res = 5'b0_0010;
                2'b01: begin
                    case (f3)
                        3'b000:  res = 5'b0_1001;
                        3'b001:  res = 5'b0_1010;
                        3'b100:  res = 5'b0_1011;
                        3'b101:  res = 5'b0_1100;
                        default: res = 5'b1_0000;
                    endcase
                end
                2'b10: begin
                    case (f3)
                        3'b000:  res = f7_zero ? 5'b0_0010 : (f7_alt ? 5'b0_0100 : 5'b1_0000);
                        3'b111:  res = f7_zero ? 5'b0_0000 : 5'b1_0000;
                        3'b110:  res = f7_zero ? 5'b0_0001 : 5'b1_0000;
                        3'b100:  res = f7_zero ? 5'b0_0011 : 5'b1_0000;
                        3'b010:  res = f7_zero ? 5'b0_0101 : 5'b1_0000;
                        3'b001:  res = f7_zero ? 5'b0_0110 : 5'b1_0000;
                        3'b101:  res = f7_zero ? 5'b0_0111 : (f7_alt ? 5'b0_1000 : 5'b1_0000);
                        default: res = 5'b1_0000;
                    endcase
                end
                2'b11: begin
                    // Immediate forms: funct7 bits are immediate data except for shifts.
                    case (f3)
                        3'b000:  res = 5'b0_0010;
                        3'b111:  res = 5'b0_0000;
                        3'b110:  res = 5'b0_0001;
                        3'b100:  res = 5'b0_0011;
                        3'b010:  res = 5'b0_0101;
                        3'b001:  res = f7_zero ? 5'b0_0110 : 5'b1_0000;
                        3'b101:  res = f7_zero ? 5'b0_0111 : (f7_alt ? 5'b0_1000 : 5'b1_0000);
                        default: res = 5'b1_0000;
                    endcase
                end
                default: res = 5'b1_0000;
            endcase
        end
        return res;
    endfunction

    logic [4:0]               dec_s;
    logic                     dec_ill_s;
    logic [OPCODE_LENGTH-1:0] dec_op_s;
    logic                     accept_s;
    logic                     out_load_s;

    logic                     out_valid_r;
    logic [OPCODE_LENGTH-1:0] out_op_r;
    logic [TAG_WIDTH-1:0]     out_tag_r;
    logic                     out_ill_r;
    logic                     skid_valid_r;
    logic [OPCODE_LENGTH-1:0] skid_op_r;
    logic [TAG_WIDTH-1:0]     skid_tag_r;
    logic                     skid_ill_r;

    assign dec_s      = decode_op(bus.ALUOp, bus.Jump, bus.Funct3, bus.Funct7);
    assign dec_ill_s  = dec_s[4];
    assign dec_op_s   = dec_s[OPCODE_LENGTH-1:0];
    assign accept_s   = bus.in_valid && !skid_valid_r;
    assign out_load_s = !out_valid_r || bus.out_ready;

    // Output register and skid entry; skid only fills while the output is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_op_r     <= {OPCODE_LENGTH{1'b0}};
            out_tag_r    <= {TAG_WIDTH{1'b0}};
            out_ill_r    <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_op_r    <= {OPCODE_LENGTH{1'b0}};
            skid_tag_r   <= {TAG_WIDTH{1'b0}};
            skid_ill_r   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (out_load_s) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_op_r     <= skid_op_r;
                out_tag_r    <= skid_tag_r;
                out_ill_r    <= skid_ill_r;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_valid_r  <= 1'b1;
                out_op_r     <= dec_op_s;
                out_tag_r    <= bus.TagIn;
                out_ill_r    <= dec_ill_s;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else if (accept_s) begin
            skid_valid_r <= 1'b1;
            skid_op_r    <= dec_op_s;
            skid_tag_r   <= bus.TagIn;
            skid_ill_r   <= dec_ill_s;
        end
    end

    assign bus.in_ready  = !skid_valid_r;
    assign bus.out_valid = out_valid_r;
    assign bus.Operation = out_op_r;
    assign bus.TagOut    = out_tag_r;
    assign bus.Illegal   = out_ill_r;

`ifdef ALU_OP_ILLEGAL_CNT_EN
    logic [CNT_WIDTH-1:0] ill_cnt_r;

    // Saturating count of illegal ops that entered the stage and survived flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ill_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (accept_s && dec_ill_s && !bus.flush && (ill_cnt_r != {CNT_WIDTH{1'b1}})) begin
            ill_cnt_r <= ill_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.IllegalCnt = ill_cnt_r;
`else
    assign bus.IllegalCnt = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode table, backpressure, flush, illegal count, async reset.
module tb_alu_op_issue;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   exp_cnt;

    alu_op_issue_if #(.OPCODE_LENGTH(4), .TAG_WIDTH(5), .CNT_WIDTH(16)) ifc ();

    alu_op_issue #(.OPCODE_LENGTH(4), .TAG_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

`ifdef ALU_OP_ILLEGAL_CNT_EN
    // Narrow-counter copy driven by the same stimulus, used to reach saturation quickly.
    alu_op_issue_if #(.OPCODE_LENGTH(4), .TAG_WIDTH(5), .CNT_WIDTH(2)) ifc2 ();
    assign ifc2.flush     = ifc.flush;
    assign ifc2.in_valid  = ifc.in_valid;
    assign ifc2.ALUOp     = ifc.ALUOp;
    assign ifc2.Jump      = ifc.Jump;
    assign ifc2.Funct3    = ifc.Funct3;
    assign ifc2.Funct7    = ifc.Funct7;
    assign ifc2.TagIn     = ifc.TagIn;
    assign ifc2.out_ready = ifc.out_ready;

    alu_op_issue #(.OPCODE_LENGTH(4), .TAG_WIDTH(5), .CNT_WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc2.slave)
    );
`endif

    typedef struct {
        logic [1:0] aluop;
        logic       jump;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] op;
        logic       ill;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aluop, input logic jump, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] tag);
        ifc.in_valid = 1'b1;
        ifc.ALUOp    = aluop;
        ifc.Jump     = jump;
        ifc.Funct3   = f3;
        ifc.Funct7   = f7;
        ifc.TagIn    = tag;
    endtask

    task automatic check_cnt(input string name);
`ifdef ALU_OP_ILLEGAL_CNT_EN
        check(name, 32'(ifc.IllegalCnt), 32'(exp_cnt));
        check({name, "_sat"}, 32'(ifc2.IllegalCnt), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
`else
        check(name, 32'(ifc.IllegalCnt), 32'd0);
`endif
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 0;
        vecs[0]  = '{2'b10, 1'b0, 3'b000, 7'b0000000, 4'b0010, 1'b0};
        vecs[1]  = '{2'b10, 1'b0, 3'b000, 7'b0100000, 4'b0100, 1'b0};
        vecs[2]  = '{2'b10, 1'b0, 3'b101, 7'b0100000, 4'b1000, 1'b0};
        vecs[3]  = '{2'b10, 1'b0, 3'b100, 7'b0000000, 4'b0011, 1'b0};
        vecs[4]  = '{2'b01, 1'b0, 3'b000, 7'b0000000, 4'b1001, 1'b0};
        vecs[5]  = '{2'b01, 1'b0, 3'b001, 7'b0000000, 4'b1010, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 3'b100, 7'b0000000, 4'b1011, 1'b0};
        vecs[7]  = '{2'b01, 1'b0, 3'b101, 7'b0000000, 4'b1100, 1'b0};
        vecs[8]  = '{2'b01, 1'b0, 3'b110, 7'b0000000, 4'b0000, 1'b1};
        vecs[9]  = '{2'b10, 1'b1, 3'b000, 7'b0000000, 4'b1101, 1'b0};
        vecs[10] = '{2'b00, 1'b0, 3'b111, 7'b1111111, 4'b0010, 1'b0};
        vecs[11] = '{2'b11, 1'b0, 3'b000, 7'b0100000, 4'b0010, 1'b0};
        vecs[12] = '{2'b11, 1'b0, 3'b001, 7'b0100000, 4'b0000, 1'b1};
        vecs[13] = '{2'b10, 1'b0, 3'b011, 7'b0000000, 4'b0000, 1'b1};
        vecs[14] = '{2'b10, 1'b0, 3'b111, 7'b0100000, 4'b0000, 1'b1};
        vecs[15] = '{2'b11, 1'b0, 3'b101, 7'b0100000, 4'b1000, 1'b0};
        vecs[16] = '{2'b10, 1'b0, 3'b001, 7'b0000000, 4'b0110, 1'b0};
        vecs[17] = '{2'b11, 1'b0, 3'b110, 7'b1111111, 4'b0001, 1'b0};

        reset         = 1'b1;
        ifc.flush     = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.ALUOp     = 2'b00;
        ifc.Jump      = 1'b0;
        ifc.Funct3    = 3'b000;
        ifc.Funct7    = 7'b0000000;
        ifc.TagIn     = 5'd0;
        ifc.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("rst_operation", 32'(ifc.Operation), 32'd0);
        check("rst_tag",       32'(ifc.TagOut),    32'd0);
        check("rst_illegal",   32'(ifc.Illegal),   32'd0);
        check_cnt("rst_cnt");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Streaming decode table, one op per cycle with out_ready high.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].aluop, vecs[i].jump, vecs[i].f3, vecs[i].f7, 5'(i + 1));
            step();
            if (vecs[i].ill) exp_cnt++;
            check($sformatf("vec%0d_valid", i), 32'(ifc.out_valid), 32'd1);
            check($sformatf("vec%0d_op", i),    32'(ifc.Operation), 32'(vecs[i].op));
            check($sformatf("vec%0d_ill", i),   32'(ifc.Illegal),   32'(vecs[i].ill));
            check($sformatf("vec%0d_tag", i),   32'(ifc.TagOut),    32'(i + 1));
        end
        ifc.in_valid = 1'b0;
        step();
        check("stream_drain_valid", 32'(ifc.out_valid), 32'd0);
        check_cnt("table_cnt");

        // Backpressure: tag 1 in output, tag 2 in skid, tag 3 held off.
        ifc.out_ready = 1'b0;
        drive(2'b10, 1'b0, 3'b000, 7'b0000000, 5'd1);
        step();
        check("bp_t1_tag",    32'(ifc.TagOut),   32'd1);
        check("bp_t1_ready",  32'(ifc.in_ready), 32'd1);
        drive(2'b10, 1'b0, 3'b000, 7'b0100000, 5'd2);
        step();
        check("bp_t2_tag",    32'(ifc.TagOut),    32'd1);
        check("bp_t2_ready",  32'(ifc.in_ready),  32'd0);
        check("bp_t2_hold",   32'(ifc.Operation), 32'd2);
        drive(2'b10, 1'b0, 3'b100, 7'b0000000, 5'd3);
        step();
        check("bp_t3_tag",    32'(ifc.TagOut),   32'd1);
        check("bp_t3_ready",  32'(ifc.in_ready), 32'd0);
        ifc.out_ready = 1'b1;
        step();
        check("bp_rel_tag2",  32'(ifc.TagOut),    32'd2);
        check("bp_rel_op2",   32'(ifc.Operation), 32'd4);
        check("bp_rel_ready", 32'(ifc.in_ready),  32'd1);
        step();
        ifc.in_valid = 1'b0;
        check("bp_rel_tag3",  32'(ifc.TagOut),    32'd3);
        check("bp_rel_op3",   32'(ifc.Operation), 32'd3);
        step();
        check("bp_empty",     32'(ifc.out_valid), 32'd0);

        // Flush with output and skid full, tag 7 offered alongside.
        ifc.out_ready = 1'b0;
        drive(2'b10, 1'b0, 3'b000, 7'b0000000, 5'd5);
        step();
        drive(2'b10, 1'b0, 3'b000, 7'b0000000, 5'd6);
        step();
        check("fl_full_ready", 32'(ifc.in_ready), 32'd0);
        drive(2'b10, 1'b0, 3'b000, 7'b0000000, 5'd7);
        ifc.flush = 1'b1;
        step();
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
        check("fl_valid", 32'(ifc.out_valid), 32'd0);
        check("fl_ready", 32'(ifc.in_ready),  32'd1);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("fl_quiet%0d", i), 32'(ifc.out_valid), 32'd0);
        end

        // Flush while the input is actually accepted: op must be discarded.
        ifc.out_ready = 1'b0;
        drive(2'b10, 1'b0, 3'b000, 7'b0000000, 5'd9);
        step();
        drive(2'b10, 1'b0, 3'b000, 7'b0000000, 5'd10);
        ifc.flush = 1'b1;
        step();
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
        check("fl2_valid", 32'(ifc.out_valid), 32'd0);
        check("fl2_ready", 32'(ifc.in_ready),  32'd1);
        ifc.out_ready = 1'b1;
        step();
        check("fl2_quiet", 32'(ifc.out_valid), 32'd0);

        // Three counted illegal ops, then one swallowed by flush.
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 1'b0, 3'b011, 7'b0000000, 5'(11 + i));
            step();
            exp_cnt++;
            check($sformatf("ill%0d_flag", i), 32'(ifc.Illegal),   32'd1);
            check($sformatf("ill%0d_op", i),   32'(ifc.Operation), 32'd0);
        end
        drive(2'b10, 1'b0, 3'b011, 7'b0000000, 5'd14);
        ifc.flush = 1'b1;
        step();
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
        check("ill_fl_valid", 32'(ifc.out_valid), 32'd0);
        step();
        check_cnt("ill_cnt");

        // Asynchronous reset between edges with both entries occupied.
        ifc.out_ready = 1'b0;
        drive(2'b10, 1'b0, 3'b000, 7'b0100000, 5'd20);
        step();
        drive(2'b10, 1'b0, 3'b000, 7'b0100000, 5'd21);
        step();
        ifc.in_valid = 1'b0;
        check("ar_pre_valid", 32'(ifc.out_valid), 32'd1);
        check("ar_pre_op",    32'(ifc.Operation), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        check("ar_valid", 32'(ifc.out_valid), 32'd0);
        check("ar_op",    32'(ifc.Operation), 32'd0);
        check("ar_tag",   32'(ifc.TagOut),    32'd0);
        check("ar_ready", 32'(ifc.in_ready),  32'd1);
        check_cnt("ar_cnt");
        @(posedge clk);
        #1;
        reset = 1'b0;
        ifc.out_ready = 1'b1;
        step();
        check("ar_post_valid", 32'(ifc.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
